// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit slice shared by two
// round-robin requesters, carry chained across cycles, LSB nibble first.
module addsub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             mode,
  input  logic [4*NIBBLES-1:0]   a0,
  input  logic [4*NIBBLES-1:0]   b0,
  input  logic [4*NIBBLES-1:0]   a1,
  input  logic [4*NIBBLES-1:0]   b1,
  output logic [1:0]             ack,
  output logic                   busy,
  output logic [1:0]             done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic            owner_r;
  logic            last_r;
  logic            mode_r;
  logic            carry_r;
  logic [IDXW-1:0] nib_idx_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    shadow_r;

  logic            winner_s;
  logic [3:0]      a_nib_s;
  logic [3:0]      b_nib_s;
  logic [3:0]      low_s;
  logic [4:0]      sum_s;

  // Round-robin pick: on contention the requester that did not win last time goes.
  always_comb begin
    winner_s = 1'b0;
    case (req_valid)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      2'b11:   winner_s = ~last_r;
      default: winner_s = 1'b0;
    endcase
  end

  // 4-bit slice; low_s exposes the carry into bit 3 for the overflow test.
  always_comb begin
    a_nib_s = a_r[{nib_idx_r, 2'b00} +: 4];
    b_nib_s = b_r[{nib_idx_r, 2'b00} +: 4] ^ {4{mode_r}};
    low_s   = {1'b0, a_nib_s[2:0]} + {1'b0, b_nib_s[2:0]} + {3'b000, carry_r};
    sum_s   = {1'b0, a_nib_s} + {1'b0, b_nib_s} + {4'b0000, carry_r};
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      mode_r    <= 1'b0;
      carry_r   <= 1'b0;
      nib_idx_r <= '0;
      a_r       <= '0;
      b_r       <= '0;
      shadow_r  <= '0;
      ack       <= 2'b00;
      busy      <= 1'b0;
      done      <= 2'b00;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      ack  <= 2'b00;
      done <= 2'b00;
      case (state_r)
        IDLE: begin
          if (req_valid != 2'b00) begin
            owner_r   <= winner_s;
            a_r       <= winner_s ? a1 : a0;
            b_r       <= winner_s ? b1 : b0;
            mode_r    <= mode[winner_s];
            carry_r   <= mode[winner_s];
            nib_idx_r <= '0;
            ack       <= winner_s ? 2'b10 : 2'b01;
            busy      <= 1'b1;
            state_r   <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          shadow_r[{nib_idx_r, 2'b00} +: 4] <= sum_s[3:0];
          carry_r <= sum_s[4];
          if (nib_idx_r == LAST_IDX) begin
            // Outputs change only here, so partial sums are never visible.
            result    <= {sum_s[3:0], shadow_r[W-5:0]};
            carry_out <= sum_s[4];
            overflow  <= low_s[3] ^ sum_s[4];
            done      <= owner_r ? 2'b10 : 2'b01;
            state_r   <= DONE;
          end else begin
            nib_idx_r <= nib_idx_r + IDXW'(1);
          end
        end
        DONE: begin
          last_r  <= owner_r;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl (NIBBLES=4): word-level reference model
// compared every cycle, plus hand-computed literal results.
module tb_addsub_seq_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    mode;
  logic [W-1:0]  a0, b0, a1, b1;
  logic [1:0]    ack;
  logic          busy;
  logic [1:0]    done;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  addsub_seq_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mode(mode),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack(ack), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Whole-word reference arithmetic: {overflow, carry_out, result}.
  function automatic logic [17:0] calc(input logic [15:0] a, input logic [15:0] b, input logic m);
    logic [16:0] full;
    logic [15:0] r;
    logic        ov;
    if (m) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else   full = {1'b0, a} + {1'b0, b};
    r = full[15:0];
    if (m) ov = (a[15] != b[15]) && (r[15] != a[15]);
    else   ov = (a[15] == b[15]) && (r[15] != a[15]);
    return {ov, full[16], r};
  endfunction

  // Reference model: cycles elapsed since capture, expected output values.
  int           m_phase;
  logic         m_owner, m_last, m_ready = 1'b0;
  logic [17:0]  m_pend;
  logic [1:0]   e_ack, e_done;
  logic         e_busy, e_co, e_ov;
  logic [W-1:0] e_res;
  logic         m_w;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1; m_phase <= 0; m_last <= 1'b1; m_owner <= 1'b0;
      e_ack <= 2'b00; e_done <= 2'b00; e_busy <= 1'b0;
      e_res <= 16'h0000; e_co <= 1'b0; e_ov <= 1'b0;
    end else if (m_ready) begin
      e_ack  <= 2'b00;
      e_done <= 2'b00;
      if (m_phase == 0) begin
        if (req_valid != 2'b00) begin
          m_w = (req_valid == 2'b11) ? ~m_last : req_valid[1];
          m_owner <= m_w;
          m_pend  <= m_w ? calc(a1, b1, mode[1]) : calc(a0, b0, mode[0]);
          e_ack   <= m_w ? 2'b10 : 2'b01;
          e_busy  <= 1'b1;
          m_phase <= 1;
        end
      end else if (m_phase <= N) begin
        m_phase <= m_phase + 1;
        if (m_phase == N) begin
          e_done <= m_owner ? 2'b10 : 2'b01;
          {e_ov, e_co, e_res} <= m_pend;
        end
      end else begin
        m_phase <= 0;
        e_busy  <= 1'b0;
        m_last  <= m_owner;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_ready)
      check("cycle", {9'd0, ack, busy, done, result, carry_out, overflow},
            {9'd0, e_ack, e_busy, e_done, e_res, e_co, e_ov});
  end

  task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b, input logic m);
    if (r) begin a1 = a; b1 = b; end else begin a0 = a; b0 = b; end
    mode[r] = m;
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_ack(input logic r);
    int k = 0;
    while (ack[r] !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    check("ack_seen", {31'd0, ack[r]}, 32'd1);
  endtask

  task automatic wait_done(input logic r);
    int k = 0;
    while (done[r] !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    check("done_seen", {31'd0, done[r]}, 32'd1);
    check("done_latency", k, N);
  endtask

  task automatic do_op(input logic r, input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [15:0] er, input logic ec, input logic eo);
    @(posedge clk); #1;
    drive(r, a, b, m);
    @(posedge clk); #1;
    wait_ack(r);
    req_valid[r] = 1'b0;
    wait_done(r);
    check("lit_result", {16'd0, result}, {16'd0, er});
    check("lit_carry", {31'd0, carry_out}, {31'd0, ec});
    check("lit_ovf", {31'd0, overflow}, {31'd0, eo});
  endtask

  logic grant_q[$];
  logic [2:0] exp_order;

  initial begin
    rst = 1'b1; req_valid = 2'b00; mode = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    do_op(1'b0, 16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0);
    do_op(1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op(1'b0, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Arbitration: both requesters held valid straight out of reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    a0 = 16'h1111; b0 = 16'h2222; a1 = 16'h5000; b1 = 16'h1000; mode = 2'b10;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      int k = 0;
      @(posedge clk); #1;
      while (ack === 2'b00 && k < 20) begin @(posedge clk); #1; k++; end
      check("arb_ack", {31'd0, ack == 2'b01 || ack == 2'b10}, 32'd1);
      grant_q.push_back(ack[1]);
      if (i == 2) req_valid = 2'b00;
      wait_done(ack[1]);
    end
    exp_order = 3'b010;
    for (int i = 0; i < 3; i++)
      check("arb_order", {31'd0, grant_q[i]}, {31'd0, exp_order[2-i]});
    check("arb_res_r0", {16'd0, result}, 32'h3333);

    // Reset on the second RUN cycle discards the operation.
    @(posedge clk); #1;
    drive(1'b0, 16'hAAAA, 16'h1111, 1'b0);
    @(posedge clk); #1;
    wait_ack(1'b0);
    req_valid = 2'b00;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {30'd0, done}, 32'd0);
    check("mid_rst_result", {16'd0, result}, 32'd0);
    do_op(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Idle hold: outputs keep the last result with no pulses.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_hold", {9'd0, ack, busy, done, result, carry_out, overflow},
            {9'd0, 2'b00, 1'b0, 2'b00, 16'h0002, 1'b0, 1'b0});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
Nibble-serial add/subtract sequencer. A single 4-bit add/sub slice is time-shared between two requesters under round-robin arbitration. Each granted operation is a (4*NIBBLES)-bit add or subtract, executed LSB-nibble first with the carry chained between cycles. Produces a full-width result, carry-out and signed overflow. It sits between the team's 4-bit add/sub datapath and the blocks that need wide arithmetic without a wide adder.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..8

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  2  bit i = requester i has an operation pending
mode  input  2  bit i = requester i op: 0 add (a+b), 1 subtract (a-b)
a0  input  W  requester 0 operand a
b0  input  W  requester 0 operand b
a1  input  W  requester 1 operand a
b1  input  W  requester 1 operand b
ack  output  2  one-cycle pulse: requester i's operands were captured
busy  output  1  high while an operation is in flight (RUN or DONE)
done  output  2  one-cycle pulse: result for requester i is valid
result  output  W  sum/difference, held until the next done
carry_out  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; ack=0, busy=0, done=0, result=0, carry_out=0, overflow=0. The last-winner pointer is set to 1, so requester 0 has priority first. The nibble index and carry register are cleared.
- Reset mid-operation: the in-flight operation is discarded. No done pulse is issued and no partial result is exposed.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req_valid != 0 at an edge: the winner's a, b and mode are captured into internal registers. owner <= winner, nib_idx <= 0, carry <= captured mode, state <= RUN.
  - ack[owner]=1 for the first RUN cycle only.
  - If req_valid == 0, the block stays in IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not the last winner wins.
  - The last-winner pointer updates on the DONE->IDLE edge.
- RUN, one nibble per cycle:
  - s = a[n] + (b[n] XOR {4{mode}}) + carry, with n = nib_idx.
  - result register nibble n <= s[3:0]; carry <= carry out of bit 3.
  - On the last nibble (n = NIBBLES-1): capture carry_out, and overflow = carry into bit W-1 XOR carry out of bit W-1. Then state <= DONE.
  - Otherwise nib_idx <= n+1.
- Result visibility: result, carry_out and overflow update only when DONE is entered. Intermediate nibbles are held in a shadow register, so outputs never show partial values.
- DONE: done[owner]=1 for exactly one cycle; state <= IDLE.
- Latency:
  - Capture at edge t; done high during the cycle after edge t+NIBBLES.
  - Next capture no earlier than edge t+NIBBLES+2.
  - Throughput: one op per NIBBLES+2 cycles.
- Requester rules:
  - Operands only need to be stable in the capture cycle.
  - A requester deasserts valid after seeing ack. If valid stays high, it is treated as a new request after DONE.
  - req_valid is ignored while busy=1.
- Width rules: all arithmetic is modulo 2^W. Wrap-around is reported only via carry_out and overflow; there is no saturation.

Test Plan:
- Add, requester 0, NIBBLES=4: a0=0x1234, b0=0x0FCC, mode=0 -> ack[0] on the cycle after capture; done[0] 4 cycles after capture with result=0x2200, carry_out=0, overflow=0.
- Subtract with borrow: a0=0x0005, b0=0x0007, mode=1 -> result=0xFFFE, carry_out=0, overflow=0. Then a0=0x0007, b0=0x0005 -> result=0x0002, carry_out=1.
- Overflow and wrap:
  - 0x7FFF+0x0001 add -> 0x8000, overflow=1, carry_out=0.
  - 0x8000-0x0001 sub -> 0x7FFF, overflow=1, carry_out=1.
  - 0xFFFF+0x0001 add -> 0x0000, carry_out=1, overflow=0.
- Arbitration: both req_valid high in the first cycle after reset, held for 3 ops -> grants in order 0,1,0. done goes to the matching owner each time. busy is never low for more than 1 cycle between ops.
- Reset mid-RUN: assert rst on the 2nd RUN cycle -> next cycle busy=0, done=0, result=0. A following add 0x0001+0x0001 completes with 0x0002.
- Idle hold: req_valid=0 for 20 cycles after an op -> result, carry_out and overflow hold their last values; ack=done=0 throughout.
